// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
// Holds the fetch FSM state encoding, the default reset PC and the sequential PC step.
package ifetch_pkg;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;

    // Fetch addresses are always word aligned; the low two bits of a target are ignored.
    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_perf.sv
// Fetch performance counters: instructions handed to decode and cycles spent waiting on memory.
// Only instantiated by ifetch_ctrl when IFETCH_PERF_EN is defined; both counters wrap at 2^32.
module ifetch_perf
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_inc,
    input  logic        stall_inc,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_stall_cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_cnt <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (fetch_inc) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (stall_inc) perf_stall_cnt <= perf_stall_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/ifetch_ctrl.sv
// Single-outstanding instruction fetch controller between instruction memory and decode.
// Define IFETCH_PERF_EN to add the perf_fetch_cnt / perf_stall_cnt counter outputs.
module ifetch_ctrl
    import ifetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          XLEN     = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetch_cnt,
    output logic [31:0]     perf_stall_cnt
`endif
);

    fetch_state_e    state, state_nxt;
    logic [XLEN-1:0] pc_p0, pc_nxt;
    logic [XLEN-1:0] inst_p1, inst_pc_p1;
    logic            rsp_take;
    logic            handoff;

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_p0;
        rsp_take  = 1'b0;
        case (state)
            ST_REQ: begin
                if (redirect_valid) begin
                    state_nxt = imem_req_ready ? ST_DROP : ST_REQ;
                end else if (imem_req_ready) begin
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (redirect_valid) begin
                    state_nxt = imem_rsp_valid ? ST_REQ : ST_DROP;
                end else if (imem_rsp_valid) begin
                    state_nxt = ST_HOLD;
                    rsp_take  = 1'b1;
                end
            end
            ST_HOLD: begin
                if (redirect_valid) begin
                    state_nxt = ST_REQ;
                end else if (inst_ready) begin
                    state_nxt = ST_REQ;
                    pc_nxt    = pc_p0 + PC_STEP;
                end
            end
            ST_DROP: begin
                // A redirect here only retargets the pc; if the stale response lands in the
                // same cycle it has still been consumed, so waiting longer would deadlock.
                if (imem_rsp_valid) state_nxt = ST_REQ;
            end
            default: state_nxt = ST_REQ;
        endcase
        if (redirect_valid) pc_nxt = align_pc(redirect_pc);
    end

    // fetch stage: state and next fetch address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_REQ;
            pc_p0 <= RESET_PC;
        end else begin
            state <= state_nxt;
            pc_p0 <= pc_nxt;
        end
    end

    // decode hand-off stage: instruction word and its pc, held until accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_p1    <= '0;
            inst_pc_p1 <= '0;
        end else if (rsp_take) begin
            inst_p1    <= imem_rsp_data;
            inst_pc_p1 <= pc_p0;
        end
    end

    assign imem_req_valid = (state == ST_REQ);
    assign imem_req_addr  = pc_p0;
    assign inst_valid     = (state == ST_HOLD) && !redirect_valid;
    assign inst           = inst_p1;
    assign inst_pc        = inst_pc_p1;
    assign handoff        = inst_valid && inst_ready;

`ifdef IFETCH_PERF_EN
    ifetch_perf u_perf (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_inc      (handoff),
        .stall_inc      ((state == ST_WAIT) || (state == ST_DROP)),
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
    );
`else
    logic unused_handoff;
    assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Self-checking bench for ifetch_ctrl: randomized memory and decode against a pc-stream model.
// The model tracks only the architectural fetch pc; every request and hand-off is scored against it.
`timescale 1ns/1ps
module tb_ifetch_ctrl;

    localparam logic [31:0] RST_PC = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ifetch_ctrl #(.RESET_PC(RST_PC), .XLEN(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
`ifdef IFETCH_PERF_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int          nchecks = 0;
    int          nerrors = 0;
    logic [31:0] exp_pc = RST_PC;
    logic [31:0] req_log[$];
    logic [31:0] fetch_log[$];
    bit          pending = 1'b0;
    int          cnt = 0;
    logic [31:0] paddr = '0;
    bit          rsp_real = 1'b0;
    bit          junk_en = 1'b0;
    bit          rand_ready = 1'b0;
    int          lat_min = 1;
    int          lat_max = 1;
    bit          hold_prev = 1'b0;
    logic [31:0] prev_inst = '0;
    logic [31:0] prev_pc = '0;

    // Instruction memory contents: a fixed scramble of the word address.
    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory model and scoreboard: drive at negedge, score 2ns later (before the next posedge).
    initial begin : mem_proc
        imem_req_ready = 1'b1;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            rsp_real = 1'b0;
            if (!rst_n) begin
                pending        = 1'b0;
                imem_rsp_valid = 1'b0;
            end else if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = memfn(paddr);
                    rsp_real       = 1'b1;
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = $urandom;
                end
            end else begin
                imem_rsp_valid = junk_en && ($urandom_range(0, 3) == 0);
                imem_rsp_data  = $urandom;
            end
            imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #2;
            if (rst_n) begin
                if (rsp_real) pending = 1'b0;
                if (redirect_valid) begin
                    nchecks++;
                    if (inst_valid !== 1'b0) begin
                        nerrors++;
                        $display("FAIL redirect_gate: inst_valid=%b required 0", inst_valid);
                    end
                end
                if (inst_valid === 1'b1) begin
                    nchecks++;
                    if (imem_req_valid !== 1'b0) begin
                        nerrors++;
                        $display("FAIL req_in_hold: imem_req_valid=%b required 0", imem_req_valid);
                    end
                    if (hold_prev) begin
                        nchecks++;
                        if (inst !== prev_inst || inst_pc !== prev_pc) begin
                            nerrors++;
                            $display("FAIL hold_stable: inst=%h pc=%h required inst=%h pc=%h",
                                     inst, inst_pc, prev_inst, prev_pc);
                        end
                    end
                end
                if (imem_req_valid && imem_req_ready) begin
                    nchecks++;
                    if (pending) begin
                        nerrors++;
                        $display("FAIL one_outstanding: request addr=%h while %h outstanding",
                                 imem_req_addr, paddr);
                    end
                    nchecks++;
                    if (imem_req_addr !== exp_pc) begin
                        nerrors++;
                        $display("FAIL req_addr: got %h required %h", imem_req_addr, exp_pc);
                    end
                    req_log.push_back(imem_req_addr);
                    pending = 1'b1;
                    paddr   = imem_req_addr;
                    cnt     = int'($urandom_range(lat_min, lat_max));
                end
                if (inst_valid && inst_ready) begin
                    nchecks++;
                    if (inst_pc !== exp_pc || inst !== memfn(exp_pc)) begin
                        nerrors++;
                        $display("FAIL handoff: inst=%h pc=%h required inst=%h pc=%h",
                                 inst, inst_pc, memfn(exp_pc), exp_pc);
                    end
                    fetch_log.push_back(inst_pc);
                    exp_pc = exp_pc + 32'd4;
                end
                if (redirect_valid) exp_pc = {redirect_pc[31:2], 2'b00};
                hold_prev = inst_valid && !inst_ready;
                prev_inst = inst;
                prev_pc   = inst_pc;
            end else begin
                pending   = 1'b0;
                hold_prev = 1'b0;
            end
        end
    end

    task automatic wait_hs(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 40 && !ok; g++) begin
            @(negedge clk);
            #3;
            ok = imem_req_valid && imem_req_ready;
        end
    endtask

    task automatic test_reset(input int lat);
        @(negedge clk);
        rst_n = 1'b0;
        redirect_valid = 1'b0;
        inst_ready = 1'b1;
        lat_min = lat;
        lat_max = lat;
        rand_ready = 1'b0;
        junk_en = 1'b0;
        #1;
        nchecks++;
        if (inst_valid !== 1'b0) begin nerrors++; $display("FAIL rst_inst_valid: got %b required 0", inst_valid); end
        nchecks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            nerrors++; $display("FAIL rst_inst: inst=%h pc=%h required 0", inst, inst_pc);
        end
        nchecks++;
        if (imem_req_addr !== RST_PC) begin nerrors++; $display("FAIL rst_pc: got %h required %h", imem_req_addr, RST_PC); end
`ifdef IFETCH_PERF_EN
        nchecks++;
        if (perf_fetch_cnt !== 32'h0 || perf_stall_cnt !== 32'h0) begin
            nerrors++; $display("FAIL rst_perf: fetch=%0d stall=%0d required 0", perf_fetch_cnt, perf_stall_cnt);
        end
`endif
        repeat (2) @(negedge clk);
        exp_pc = RST_PC;
        req_log.delete();
        fetch_log.delete();
        rst_n = 1'b1;
        #3;
        nchecks++;
        if (imem_req_valid !== 1'b1) begin nerrors++; $display("FAIL rst_req_valid: got %b required 1", imem_req_valid); end
    endtask

    task automatic test_sequential();
        int guard = 0;
        while (req_log.size() < 3 && guard < 40) begin
            @(negedge clk);
            #3;
            guard++;
        end
        nchecks++;
        if (req_log.size() < 3) begin
            nerrors++; $display("FAIL seq_timeout: %0d requests required 3", req_log.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                nchecks++;
                if (req_log[i] !== RST_PC + 32'(4 * i)) begin
                    nerrors++; $display("FAIL seq_addr%0d: got %h required %h", i, req_log[i], RST_PC + 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] i0, p0;
        bit          got = 1'b0;
        @(negedge clk);
        inst_ready = 1'b0;
        for (int g = 0; g < 20; g++) begin
            #3;
            if (inst_valid === 1'b1) begin got = 1'b1; break; end
            @(negedge clk);
        end
        nchecks++;
        if (!got) begin
            nerrors++; $display("FAIL stall_timeout: inst_valid=%b required 1", inst_valid);
        end else begin
            i0 = inst;
            p0 = inst_pc;
            repeat (5) begin
                @(negedge clk);
                #3;
                nchecks++;
                if (inst_valid !== 1'b1 || inst !== i0 || inst_pc !== p0) begin
                    nerrors++; $display("FAIL stall_hold: valid=%b inst=%h pc=%h required 1 %h %h", inst_valid, inst, inst_pc, i0, p0);
                end
                nchecks++;
                if (imem_req_valid !== 1'b0) begin
                    nerrors++; $display("FAIL stall_noreq: imem_req_valid=%b required 0", imem_req_valid);
                end
            end
        end
        @(negedge clk);
        inst_ready = 1'b1;
    endtask

    // Redirect in WAIT; checks that the next request goes to the aligned target with no hand-off first.
    task automatic test_redirect(input int lat, input logic [31:0] tgt, input string name);
        bit          ok, got = 1'b0, saw = 1'b0;
        logic [31:0] a = '0;
        lat_min = lat;
        lat_max = lat;
        inst_ready = 1'b1;
        wait_hs(ok);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = tgt;
        @(negedge clk);
        redirect_valid = 1'b0;
        for (int g = 0; g < 40; g++) begin
            #3;
            if (inst_valid === 1'b1) saw = 1'b1;
            if (imem_req_valid && imem_req_ready) begin got = 1'b1; a = imem_req_addr; break; end
            @(negedge clk);
        end
        nchecks++;
        if (!ok || !got || a !== {tgt[31:2], 2'b00}) begin
            nerrors++; $display("FAIL %s_addr: got %h required %h", name, a, {tgt[31:2], 2'b00});
        end
        nchecks++;
        if (saw) begin nerrors++; $display("FAIL %s_novalid: inst_valid seen=1 required 0", name); end
    endtask

    task automatic test_wrap();
        int guard = 0;
        lat_min = 1;
        lat_max = 1;
        inst_ready = 1'b1;
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        req_log.delete();
        while (req_log.size() < 2 && guard < 40) begin
            #3;
            guard++;
            if (req_log.size() < 2) @(negedge clk);
        end
        nchecks++;
        if (req_log.size() < 2 || req_log[0] !== 32'hFFFF_FFFC || req_log[1] !== 32'h0) begin
            nerrors++;
            $display("FAIL wrap: %0d requests, first=%h second=%h required fffffffc 00000000",
                     req_log.size(), req_log.size() > 0 ? req_log[0] : 32'hx, req_log.size() > 1 ? req_log[1] : 32'hx);
        end
    endtask

    task automatic test_random();
        int n0;
        rand_ready = 1'b1;
        junk_en = 1'b1;
        lat_min = 1;
        lat_max = 4;
        n0 = fetch_log.size();
        repeat (3000) begin
            @(negedge clk);
            inst_ready = ($urandom_range(0, 2) != 0);
            redirect_valid = ($urandom_range(0, 24) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
        end
        @(negedge clk);
        redirect_valid = 1'b0;
        inst_ready = 1'b0;
        #3;
        nchecks++;
        if (fetch_log.size() - n0 < 100) begin
            nerrors++; $display("FAIL random_progress: %0d hand-offs required >= 100", fetch_log.size() - n0);
        end
`ifdef IFETCH_PERF_EN
        nchecks++;
        if (perf_fetch_cnt !== 32'(fetch_log.size())) begin
            nerrors++; $display("FAIL random_perf_fetch: got %0d required %0d", perf_fetch_cnt, fetch_log.size());
        end
`endif
        rand_ready = 1'b0;
        junk_en = 1'b0;
        @(negedge clk);
        inst_ready = 1'b1;
    endtask

    task automatic test_reset_midflight();
        bit ok;
        int guard = 0;
        lat_min = 4;
        lat_max = 4;
        wait_hs(ok);
        test_reset(1);
        while (fetch_log.size() < 1 && guard < 40) begin
            @(negedge clk);
            #3;
            guard++;
        end
        nchecks++;
        if (!ok || fetch_log.size() < 1 || fetch_log[0] !== RST_PC) begin
            nerrors++; $display("FAIL midflight: %0d hand-offs, first pc=%h required %h", fetch_log.size(),
                                fetch_log.size() > 0 ? fetch_log[0] : 32'hx, RST_PC);
        end
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        int n = 0;
        test_reset(2);
        for (int g = 0; g < 60 && n < 3; g++) begin
            @(negedge clk);
            #3;
            if (inst_valid && inst_ready) n++;
        end
        @(negedge clk);
        #3;
        nchecks++;
        if (perf_fetch_cnt !== 32'd3 || perf_stall_cnt !== 32'd6) begin
            nerrors++; $display("FAIL perf_counts: fetch=%0d stall=%0d required 3 6", perf_fetch_cnt, perf_stall_cnt);
        end
    endtask
`endif

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        inst_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        test_reset(1);
        test_sequential();
        test_stall();
        test_redirect(3, 32'h8000_0102, "redir_wait");
        test_redirect(1, $urandom, "redir_rsp");
        test_wrap();
        test_random();
        test_reset_midflight();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
        $finish;
    end

endmodule
